// File: rtl/vpu_selftest_seq.sv
// VPU self-test sequencer: walks an external instruction/golden/mask table, issues each entry,
// compares the masked result and stops on the first mismatch or timeout. Build macro VPU_SELFTEST_LOOP_EN enables endless sweeps.
module vpu_selftest_seq #(
    parameter int NUM_TESTS      = 10,
    parameter int DLEN           = 64,
    parameter int INSTR_W        = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int HB_BITS        = 24,
    localparam int IW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int PW = $clog2(NUM_TESTS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [IW-1:0]      tst_idx,
    input  logic [INSTR_W-1:0] tst_instr,
    input  logic [DLEN-1:0]    tst_golden,
    input  logic [DLEN-1:0]    tst_mask,
    output logic               issue_valid,
    output logic [INSTR_W-1:0] issue_instr,
    input  logic               issue_ready,
    input  logic               res_valid,
    input  logic [DLEN-1:0]    res_data,
    output logic               res_ready,
    output logic [PW-1:0]      pass_count,
    output logic [IW-1:0]      fail_idx,
    output logic               fail_timeout,
    output logic [DLEN-1:0]    result_reg,
`ifdef VPU_SELFTEST_LOOP_EN
    output logic [15:0]        loop_count,
`endif
    output logic [3:0]         led
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_NEXT, S_PASS, S_FAIL
    } state_t;

    state_t            state_reg;
    logic [IW-1:0]     idx_reg;
    logic [PW-1:0]     pass_cnt_reg;
    logic [IW-1:0]     fail_idx_reg;
    logic              fail_tmo_reg;
    logic [DLEN-1:0]   result_data_reg;
    logic [TW-1:0]     tmo_cnt_reg;
    logic [HB_BITS:0]  hb_cnt_reg;
    logic              issue_valid_reg;
    logic              res_ready_reg;
    logic              pass_reg;
    logic              fail_reg;
    logic              busy_reg;
`ifdef VPU_SELFTEST_LOOP_EN
    logic [15:0]       loop_cnt_reg;
`endif

    logic              last_test;
    logic              tmo_expired;
    logic              mismatch;
    logic [TW-1:0]     tmo_cnt_next;

    assign last_test   = (idx_reg == IW'(NUM_TESTS - 1));
    assign tmo_expired = (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
    assign mismatch    = |((result_data_reg ^ tst_golden) & tst_mask);
    // Saturate at the limit so a handshake on the final cycle leaves WAIT with no slack left.
    assign tmo_cnt_next = tmo_expired ? tmo_cnt_reg : tmo_cnt_reg + TW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            pass_cnt_reg    <= '0;
            fail_idx_reg    <= '0;
            fail_tmo_reg    <= 1'b0;
            result_data_reg <= '0;
            tmo_cnt_reg     <= '0;
            hb_cnt_reg      <= '0;
            issue_valid_reg <= 1'b0;
            res_ready_reg   <= 1'b0;
            pass_reg        <= 1'b0;
            fail_reg        <= 1'b0;
            busy_reg        <= 1'b0;
`ifdef VPU_SELFTEST_LOOP_EN
            loop_cnt_reg    <= '0;
`endif
        end else begin
            hb_cnt_reg <= hb_cnt_reg + (HB_BITS + 1)'(1);
            case (state_reg)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start) begin
                        idx_reg         <= '0;
                        pass_cnt_reg    <= '0;
                        fail_idx_reg    <= '0;
                        fail_tmo_reg    <= 1'b0;
                        tmo_cnt_reg     <= '0;
                        issue_valid_reg <= 1'b1;
                        pass_reg        <= 1'b0;
                        fail_reg        <= 1'b0;
                        busy_reg        <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        issue_valid_reg <= 1'b0;
                        res_ready_reg   <= 1'b1;
                        tmo_cnt_reg     <= tmo_cnt_next;
                        state_reg       <= S_WAIT;
                    end else if (tmo_expired) begin
                        issue_valid_reg <= 1'b0;
                        fail_tmo_reg    <= 1'b1;
                        fail_idx_reg    <= idx_reg;
                        busy_reg        <= 1'b0;
                        fail_reg        <= 1'b1;
                        state_reg       <= S_FAIL;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_next;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        result_data_reg <= res_data;
                        res_ready_reg   <= 1'b0;
                        tmo_cnt_reg     <= tmo_cnt_next;
                        state_reg       <= S_CHECK;
                    end else if (tmo_expired) begin
                        res_ready_reg <= 1'b0;
                        fail_tmo_reg  <= 1'b1;
                        fail_idx_reg  <= idx_reg;
                        busy_reg      <= 1'b0;
                        fail_reg      <= 1'b1;
                        state_reg     <= S_FAIL;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_next;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        fail_idx_reg <= idx_reg;
                        busy_reg     <= 1'b0;
                        fail_reg     <= 1'b1;
                        state_reg    <= S_FAIL;
                    end else begin
                        pass_cnt_reg <= pass_cnt_reg + PW'(1);
                        state_reg    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (last_test) begin
`ifdef VPU_SELFTEST_LOOP_EN
                        idx_reg         <= '0;
                        pass_cnt_reg    <= '0;
                        tmo_cnt_reg     <= '0;
                        issue_valid_reg <= 1'b1;
                        state_reg       <= S_ISSUE;
                        if (loop_cnt_reg != 16'hFFFF) begin
                            loop_cnt_reg <= loop_cnt_reg + 16'd1;
                        end
`else
                        busy_reg  <= 1'b0;
                        pass_reg  <= 1'b1;
                        state_reg <= S_PASS;
`endif
                    end else begin
                        idx_reg         <= idx_reg + IW'(1);
                        tmo_cnt_reg     <= '0;
                        issue_valid_reg <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Table lookup is combinational on idx_reg, which is frozen throughout ISSUE.
    assign issue_instr  = issue_valid_reg ? tst_instr : '0;
    assign issue_valid  = issue_valid_reg;
    assign res_ready    = res_ready_reg;
    assign tst_idx      = idx_reg;
    assign pass_count   = pass_cnt_reg;
    assign fail_idx     = fail_idx_reg;
    assign fail_timeout = fail_tmo_reg;
    assign result_reg   = result_data_reg;

`ifdef VPU_SELFTEST_LOOP_EN
    assign loop_count = loop_cnt_reg;
    assign led = {hb_cnt_reg[HB_BITS], busy_reg, fail_reg,
                  (loop_cnt_reg != 16'd0) && !fail_reg && !pass_reg};
`else
    assign led = {hb_cnt_reg[HB_BITS], busy_reg, fail_reg, pass_reg};
`endif

endmodule

// File: tb/tb_vpu_selftest_seq.sv
// Self-checking bench for vpu_selftest_seq: VPU responder model, issue-order scoreboard and
// a small table-walk predictor for final status, cycle count and captured result.
module tb_vpu_selftest_seq;
    localparam int NT      = 10;
    localparam int DLEN    = 64;
    localparam int INSTR_W = 32;
    localparam int TO      = 16;
    localparam int HB      = 4;

    logic               clk, rst_n, start;
    logic [3:0]         tst_idx;
    logic [INSTR_W-1:0] tst_instr, issue_instr;
    logic [DLEN-1:0]    tst_golden, tst_mask, res_data, result_reg;
    logic               issue_valid, issue_ready, res_valid, res_ready, fail_timeout;
    logic [3:0]         pass_count, fail_idx, led;
`ifdef VPU_SELFTEST_LOOP_EN
    logic [15:0]        loop_count;
`endif

    logic [INSTR_W-1:0] instr_arr  [NT];
    logic [DLEN-1:0]    golden_arr [NT];
    logic [DLEN-1:0]    mask_arr   [NT];
    logic [DLEN-1:0]    err_arr    [NT];
    int                 lat_arr    [NT];
    int                 hold_cycles, drop_idx;
    bit                 stray_en;

    logic [INSTR_W-1:0] exp_q [$];
    logic [INSTR_W-1:0] obs_q [$];
    int                 n_cmp, n_bad;
    logic [DLEN-1:0]    model_res;

    assign tst_instr  = instr_arr[tst_idx];
    assign tst_golden = golden_arr[tst_idx];
    assign tst_mask   = mask_arr[tst_idx];

    vpu_selftest_seq #(
        .NUM_TESTS(NT), .DLEN(DLEN), .INSTR_W(INSTR_W), .TIMEOUT_CYCLES(TO), .HB_BITS(HB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tst_idx(tst_idx),
        .tst_instr(tst_instr), .tst_golden(tst_golden), .tst_mask(tst_mask),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .pass_count(pass_count), .fail_idx(fail_idx), .fail_timeout(fail_timeout),
        .result_reg(result_reg),
`ifdef VPU_SELFTEST_LOOP_EN
        .loop_count(loop_count),
`endif
        .led(led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VPU responder: drives on the falling edge; result arrives lat_arr[idx] cycles after the accept.
    int issue_age, wait_cnt, cur_idx;
    bit pending;
    initial begin
        issue_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        issue_age = 0; wait_cnt = 0; cur_idx = 0; pending = 1'b0;
        forever begin
            @(negedge clk);
            res_valid = 1'b0;
            if (issue_valid === 1'b1) begin
                issue_ready = !(tst_idx == 4'd0 && issue_age < hold_cycles);
                if (!issue_ready && stray_en) begin
                    res_valid = issue_age[0];
                    res_data  = '1;
                end
                issue_age++;
                if (issue_ready) begin
                    obs_q.push_back(issue_instr);
                    cur_idx  = int'(tst_idx);
                    wait_cnt = lat_arr[cur_idx];
                    pending  = (drop_idx != cur_idx);
                end
            end else begin
                issue_ready = 1'b0;
                issue_age   = 0;
                if (pending) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        res_valid = 1'b1;
                        res_data  = golden_arr[cur_idx] ^ err_arr[cur_idx];
                        pending   = 1'b0;
                    end
                end
            end
        end
    end

    task automatic set_defaults();
        for (int i = 0; i < NT; i++) begin
            instr_arr[i]  = 32'hC0DE_0000 | 32'(i * 17);
            golden_arr[i] = {32'hDEAD_BEEF, 32'((i ^ 4) << 16)};
            mask_arr[i]   = '1;
            err_arr[i]    = '0;
            lat_arr[i]    = 3;
        end
        hold_cycles = 0; drop_idx = -1; stray_en = 1'b0;
        exp_q.delete(); obs_q.delete();
    endtask

    // Walks the table as the sequencer should, queues expected issues and returns expected status.
    task automatic predict(output int e_pass, output bit e_fail, output int e_fidx,
                           output bit e_tmo, output logic [DLEN-1:0] e_res, output int e_cyc);
        bit stop;
        int h;
        e_pass = 0; e_fail = 0; e_fidx = 0; e_tmo = 0; e_res = model_res; e_cyc = 1; stop = 0;
        for (int i = 0; i < NT && !stop; i++) begin
            h = (i == 0) ? hold_cycles : 0;
            exp_q.push_back(instr_arr[i]);
            if (i == drop_idx || h + lat_arr[i] > TO - 1) begin
                e_fail = 1; e_tmo = 1; e_fidx = i; e_cyc += TO; stop = 1;
            end else begin
                e_res = golden_arr[i] ^ err_arr[i];
                if ((err_arr[i] & mask_arr[i]) != '0) begin
                    e_fail = 1; e_fidx = i; e_cyc += h + lat_arr[i] + 2; stop = 1;
                end else begin
                    e_pass++; e_cyc += h + lat_arr[i] + 3;
                end
            end
        end
        model_res = e_res;
    endtask

    task automatic run_seq(output int cyc, output bit done);
        @(negedge clk); start = 1'b1; cyc = 0; done = 1'b0;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (cyc < 400 && !done) begin
            @(negedge clk);
            cyc++;
            done = led[0] | led[1];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (led !== 4'b0000) begin n_bad++; $display("FAIL reset_led: got %b want 0000", led); end
        n_cmp++; if ({issue_valid, res_ready, fail_timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl: got %b want 000", {issue_valid, res_ready, fail_timeout}); end
        n_cmp++; if ({tst_idx, pass_count, fail_idx} !== 12'h000) begin n_bad++; $display("FAIL reset_cnt: got %h want 000", {tst_idx, pass_count, fail_idx}); end
        n_cmp++; if (result_reg !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_reg); end
        repeat (15) @(negedge clk);
        n_cmp++; if (led !== 4'b0000) begin n_bad++; $display("FAIL heartbeat_low: got %b want 0000", led); end
        @(negedge clk);
        n_cmp++; if (led !== 4'b1000) begin n_bad++; $display("FAIL heartbeat_high: got %b want 1000", led); end
    endtask

    task automatic test_all_pass();
        int cyc, e_pass, e_fidx, e_cyc; bit done, e_fail, e_tmo; logic [DLEN-1:0] e_res; logic [INSTR_W-1:0] e, o;
        set_defaults();
        predict(e_pass, e_fail, e_fidx, e_tmo, e_res, e_cyc);
        run_seq(cyc, done);
        n_cmp++; if (!done) begin n_bad++; $display("FAIL all_pass_done: no end state, led=%b", led); end
        n_cmp++; if (cyc != e_cyc) begin n_bad++; $display("FAIL all_pass_cycles: got %0d want %0d", cyc, e_cyc); end
        n_cmp++; if (led[2:0] !== 3'b001) begin n_bad++; $display("FAIL all_pass_led: got %b want 001", led[2:0]); end
        n_cmp++; if (pass_count !== 4'(e_pass)) begin n_bad++; $display("FAIL all_pass_count: got %0d want %0d", pass_count, e_pass); end
        n_cmp++; if (fail_timeout !== e_tmo) begin n_bad++; $display("FAIL all_pass_tmo: got %b want %b", fail_timeout, e_tmo); end
        n_cmp++; if (result_reg !== e_res) begin n_bad++; $display("FAIL all_pass_result: got %h want %h", result_reg, e_res); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL all_pass_sb: issued %h want %h", o, e); end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL all_pass_sb_extra: got %0d extra issues want 0", obs_q.size()); end
    endtask

    task automatic test_mismatch();
        int cyc, e_pass, e_fidx, e_cyc; bit done, e_fail, e_tmo; logic [DLEN-1:0] e_res; logic [INSTR_W-1:0] e, o;
        set_defaults();
        err_arr[4] = 64'h1;
        predict(e_pass, e_fail, e_fidx, e_tmo, e_res, e_cyc);
        run_seq(cyc, done);
        n_cmp++; if (!done) begin n_bad++; $display("FAIL mismatch_done: no end state, led=%b", led); end
        n_cmp++; if (cyc != e_cyc) begin n_bad++; $display("FAIL mismatch_cycles: got %0d want %0d", cyc, e_cyc); end
        n_cmp++; if (led[2:0] !== 3'b010) begin n_bad++; $display("FAIL mismatch_led: got %b want 010", led[2:0]); end
        n_cmp++; if (pass_count !== 4'(e_pass)) begin n_bad++; $display("FAIL mismatch_count: got %0d want %0d", pass_count, e_pass); end
        n_cmp++; if (fail_idx !== 4'(e_fidx)) begin n_bad++; $display("FAIL mismatch_idx: got %0d want %0d", fail_idx, e_fidx); end
        n_cmp++; if (fail_timeout !== e_tmo) begin n_bad++; $display("FAIL mismatch_tmo: got %b want %b", fail_timeout, e_tmo); end
        n_cmp++; if (result_reg !== 64'hDEAD_BEEF_0000_0001) begin n_bad++; $display("FAIL mismatch_result: got %h want deadbeef00000001", result_reg); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL mismatch_sb: issued %h want %h", o, e); end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL mismatch_sb_extra: got %0d extra issues want 0", obs_q.size()); end
    endtask

    task automatic test_masked();
        int cyc, e_pass, e_fidx, e_cyc; bit done, e_fail, e_tmo; logic [DLEN-1:0] e_res;
        set_defaults();
        err_arr[4]  = 64'h1;
        mask_arr[4] = 64'hFFFF_FFFF_FFFF_FFFE;
        predict(e_pass, e_fail, e_fidx, e_tmo, e_res, e_cyc);
        run_seq(cyc, done);
        n_cmp++; if (!done) begin n_bad++; $display("FAIL masked_done: no end state, led=%b", led); end
        n_cmp++; if (cyc != e_cyc) begin n_bad++; $display("FAIL masked_cycles: got %0d want %0d", cyc, e_cyc); end
        n_cmp++; if (led[2:0] !== 3'b001) begin n_bad++; $display("FAIL masked_led: got %b want 001", led[2:0]); end
        n_cmp++; if (pass_count !== 4'(e_pass)) begin n_bad++; $display("FAIL masked_count: got %0d want %0d", pass_count, e_pass); end
        n_cmp++; if (fail_idx !== 4'(e_fidx)) begin n_bad++; $display("FAIL masked_idx: got %0d want %0d", fail_idx, e_fidx); end
        n_cmp++; if (exp_q.size() != obs_q.size()) begin n_bad++; $display("FAIL masked_sb: issued %0d want %0d", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_timeout();
        int cyc, e_pass, e_fidx, e_cyc; bit done, e_fail, e_tmo; logic [DLEN-1:0] e_res;
        set_defaults();
        drop_idx = 2;
        predict(e_pass, e_fail, e_fidx, e_tmo, e_res, e_cyc);
        run_seq(cyc, done);
        n_cmp++; if (!done) begin n_bad++; $display("FAIL timeout_done: no end state, led=%b", led); end
        n_cmp++; if (cyc != e_cyc) begin n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", cyc, e_cyc); end
        n_cmp++; if (led[2:0] !== 3'b010) begin n_bad++; $display("FAIL timeout_led: got %b want 010", led[2:0]); end
        n_cmp++; if (fail_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_flag: got %b want 1", fail_timeout); end
        n_cmp++; if (fail_idx !== 4'(e_fidx)) begin n_bad++; $display("FAIL timeout_idx: got %0d want %0d", fail_idx, e_fidx); end
        n_cmp++; if (pass_count !== 4'(e_pass)) begin n_bad++; $display("FAIL timeout_count: got %0d want %0d", pass_count, e_pass); end
        n_cmp++; if (result_reg !== e_res) begin n_bad++; $display("FAIL timeout_result: got %h want %h", result_reg, e_res); end
    endtask

    task automatic test_timeout_edge();
        int cyc, e_pass, e_fidx, e_cyc; bit done, e_fail, e_tmo; logic [DLEN-1:0] e_res;
        set_defaults();
        lat_arr[2] = TO - 1;
        predict(e_pass, e_fail, e_fidx, e_tmo, e_res, e_cyc);
        run_seq(cyc, done);
        n_cmp++; if (!done) begin n_bad++; $display("FAIL tmo_edge_done: no end state, led=%b", led); end
        n_cmp++; if (cyc != e_cyc) begin n_bad++; $display("FAIL tmo_edge_cycles: got %0d want %0d", cyc, e_cyc); end
        n_cmp++; if (led[2:0] !== 3'b001) begin n_bad++; $display("FAIL tmo_edge_led: got %b want 001", led[2:0]); end
        n_cmp++; if (fail_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_edge_flag: got %b want 0", fail_timeout); end
        n_cmp++; if (pass_count !== 4'(e_pass)) begin n_bad++; $display("FAIL tmo_edge_count: got %0d want %0d", pass_count, e_pass); end
    endtask

    task automatic test_ready_stall();
        int cyc, e_pass, e_fidx, e_cyc; bit done, e_fail, e_tmo; logic [DLEN-1:0] e_res, prev_res;
        set_defaults();
        hold_cycles = 5; stray_en = 1'b1; prev_res = model_res;
        predict(e_pass, e_fail, e_fidx, e_tmo, e_res, e_cyc);
        @(negedge clk); start = 1'b1; cyc = 0; done = 1'b0;
        @(negedge clk); start = 1'b0; cyc = 1;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin @(negedge clk); cyc++; end
            start = (k == 3);
            n_cmp++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: cycle %0d got %b want 1", k, issue_valid); end
            n_cmp++; if (issue_instr !== instr_arr[0]) begin n_bad++; $display("FAIL stall_instr: cycle %0d got %h want %h", k, issue_instr, instr_arr[0]); end
        end
        start = 1'b0;
        n_cmp++; if (result_reg !== prev_res) begin n_bad++; $display("FAIL stall_stray_res: got %h want %h", result_reg, prev_res); end
        while (cyc < 400 && !done) begin
            @(negedge clk);
            cyc++;
            done = led[0] | led[1];
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL stall_done: no end state, led=%b", led); end
        n_cmp++; if (cyc != e_cyc) begin n_bad++; $display("FAIL stall_cycles: got %0d want %0d", cyc, e_cyc); end
        n_cmp++; if (pass_count !== 4'(e_pass)) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", pass_count, e_pass); end
        n_cmp++; if (exp_q.size() != obs_q.size()) begin n_bad++; $display("FAIL stall_sb: issued %0d want %0d", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid_wait();
        int cyc; bit hit;
        set_defaults();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 0; hit = 1'b0;
        while (cyc < 200 && !hit) begin
            @(negedge clk);
            cyc++;
            hit = (tst_idx == 4'd3) && res_ready;
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL rst_mid_reach: WAIT of test 3 not seen, idx=%0d", tst_idx); end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_res = '0;
        n_cmp++; if (led !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_led: got %b want 0000", led); end
        n_cmp++; if ({issue_valid, res_ready, fail_timeout} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_ctl: got %b want 000", {issue_valid, res_ready, fail_timeout}); end
        n_cmp++; if ({tst_idx, pass_count, fail_idx} !== 12'h000) begin n_bad++; $display("FAIL rst_mid_cnt: got %h want 000", {tst_idx, pass_count, fail_idx}); end
        n_cmp++; if (result_reg !== '0 || issue_instr !== '0) begin n_bad++; $display("FAIL rst_mid_data: result %h instr %h want 0", result_reg, issue_instr); end
        repeat (6) @(negedge clk);
        n_cmp++; if (result_reg !== '0) begin n_bad++; $display("FAIL rst_mid_late_res: got %h want 0", result_reg); end
        n_cmp++; if (led[2:0] !== 3'b000) begin n_bad++; $display("FAIL rst_mid_idle: got %b want 000", led[2:0]); end
        obs_q.delete();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; model_res = '0;
        rst_n = 1'b0; start = 1'b0;
        set_defaults();
        test_reset();
        test_all_pass();
        test_mismatch();
        test_masked();
        test_timeout();
        test_timeout_edge();
        test_ready_stall();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vpu_selftest_seq.md
Name: vpu_selftest_seq

Overview:
Parametrised on-chip self-test sequencer for the VPU. It walks an external test table of instruction, golden result and compare mask. Each instruction is issued through a valid/ready port, the result is captured and compared under the mask, and the sequencer stops on the first mismatch or timeout. It sits between the VPU core and the board-level wrapper and drives the status LEDs. It also exposes pass count, failing index and captured data for debug.

Parameters:
NUM_TESTS, 10, number of table entries; legal range 1..256.
DLEN, 64, result and golden width in bits.
INSTR_W, 32, instruction width.
TIMEOUT_CYCLES, 4096, per-test cycle limit counted across ISSUE and WAIT; must be 2 or more.
HB_BITS, 24, heartbeat divider; led[3] toggles every 2^HB_BITS cycles.

Ports:
clk, in, 1, single clock.
rst_n, in, 1, synchronous active-low reset.
start, in, 1, one-cycle pulse; honoured only in IDLE, PASS or FAIL.
tst_idx, out, IW = max(1, $clog2(NUM_TESTS)), current table index.
tst_instr, in, INSTR_W, table instruction for tst_idx; combinational lookup.
tst_golden, in, DLEN, expected result for tst_idx.
tst_mask, in, DLEN, compare mask; 1 = bit is checked.
issue_valid, out, 1, instruction valid.
issue_instr, out, INSTR_W, instruction payload.
issue_ready, in, 1, VPU accepts the instruction.
res_valid, in, 1, VPU result valid.
res_data, in, DLEN, VPU result.
res_ready, out, 1, high only in WAIT.
pass_count, out, $clog2(NUM_TESTS+1), number of tests passed.
fail_idx, out, IW, index of the failing test.
fail_timeout, out, 1, failure was caused by timeout.
result_reg, out, DLEN, last captured result.
led, out, 4, [0] PASS, [1] FAIL, [2] BUSY, [3] heartbeat.

Behaviour:
- Reset (synchronous, rst_n = 0 at a clk edge) sets every output and register to 0 and the state to IDLE. This includes led, tst_idx, pass_count, fail_idx, fail_timeout, result_reg and the heartbeat counter.
- Reset mid-operation abandons the test immediately. Any in-flight VPU result arriving later is ignored because res_ready is 0.
- States: IDLE, ISSUE, WAIT, CHECK, NEXT, PASS, FAIL.
- IDLE/PASS/FAIL with start=1: clear tst_idx, pass_count, fail_idx, fail_timeout and the timeout counter, then go to ISSUE. start is ignored in every other state.
- ISSUE:
  - issue_valid = 1 and issue_instr = tst_instr.
  - issue_valid is held until issue_valid && issue_ready, then go to WAIT.
  - The instruction must not change while issue_valid=1 and issue_ready=0.
- WAIT: res_ready = 1. On res_valid, capture res_data into result_reg and go to CHECK.
- CHECK (one cycle):
  - Compare ((result_reg ^ tst_golden) & tst_mask) against 0.
  - Zero: pass_count += 1, go to NEXT.
  - Nonzero: fail_idx = tst_idx, go to FAIL.
- NEXT (one cycle):
  - If tst_idx == NUM_TESTS-1, go to PASS.
  - Otherwise tst_idx += 1, clear the timeout counter and go to ISSUE.
- Timeout:
  - The counter increments every cycle in ISSUE and WAIT.
  - When the count reaches TIMEOUT_CYCLES-1 without a handshake, go to FAIL with fail_timeout=1 and fail_idx = tst_idx.
  - If res_valid (in WAIT) or the issue handshake (in ISSUE) coincides with the timeout cycle, the handshake wins and no timeout is recorded.
- Minimum latency per test: 1 ISSUE + 1 WAIT + CHECK + NEXT = 4 cycles when ready and valid are immediate.
- res_valid outside WAIT is ignored and result_reg is unchanged.
- PASS and FAIL are terminal until start or reset. tst_idx and the debug outputs hold their values.
- LED outputs:
  - led[0] = (state == PASS).
  - led[1] = (state == FAIL).
  - led[2] = state in {ISSUE, WAIT, CHECK, NEXT}.
  - led[3] = heartbeat counter MSB; free-running and unaffected by start.
- NUM_TESTS = 1: tst_idx is held at 0, and NEXT goes directly to PASS.

Optional Feature:
- Macro: VPU_SELFTEST_LOOP_EN.
- Defined:
  - Adds an output loop_count[15:0] (reset 0).
  - On the last test, NEXT returns to ISSUE with tst_idx=0 and pass_count=0, and increments loop_count with saturation at 0xFFFF.
  - led[0] = (loop_count != 0) && state != FAIL.
  - FAIL stays terminal. PASS is unreachable.
- Undefined: single pass as described above; no loop_count port.

Test Plan:
- Defaults; VPU model with ready=1 and a 3-cycle result; all golden values match, mask all-ones -> PASS reached; pass_count=10; led=4'b0001 (plus heartbeat); per-test period 6 cycles.
- Test 4 returns 0xDEAD_BEEF_0000_0001 against golden 0xDEAD_BEEF_0000_0000 -> FAIL; fail_idx=4; pass_count=4; fail_timeout=0; result_reg=0xDEAD_BEEF_0000_0001; led[1]=1.
- Same mismatch with mask = 0xFFFF_FFFF_FFFF_FFFE -> test 4 passes; final PASS with pass_count=10.
- TIMEOUT_CYCLES=16; VPU never asserts res_valid for test 2 -> FAIL exactly 16 cycles after ISSUE entry; fail_timeout=1; fail_idx=2. A second run with res_valid arriving exactly on count 15 -> no timeout, test passes.
- issue_ready held low for 5 cycles on test 0 -> issue_valid stays high and issue_instr stays stable; start pulses and stray res_valid pulses in that window have no effect. rst_n=0 for one cycle mid-WAIT -> all outputs 0, state IDLE.
- VPU_SELFTEST_LOOP_EN defined, NUM_TESTS=3, all pass -> loop_count reaches 2 after 2 sweeps; led[0]=1. Inject a failure in sweep 3 -> FAIL; loop_count frozen at 2.
